// File: rtl/exc_ctrl_pkg.sv
// rtl/exc_ctrl_pkg.sv - shared exception codes, MEM flag indices, CP0 register numbers, FSM states
//
// Purpose: common definitions for the MEM-stage exception arbiter and its
//          CP0 forwarding helper.
// Ports:   none (package).

package exc_ctrl_pkg;

  // excepttype encodings understood by the CP0 register block
  localparam logic [31:0] ExcNone      = 32'h0000_0000;
  localparam logic [31:0] ExcInterrupt = 32'h0000_0001;
  localparam logic [31:0] ExcSyscall   = 32'h0000_0008;
  localparam logic [31:0] ExcInvInst   = 32'h0000_000a;
  localparam logic [31:0] ExcOverflow  = 32'h0000_000c;
  localparam logic [31:0] ExcTrap      = 32'h0000_000d;
  localparam logic [31:0] ExcEret      = 32'h0000_000e;
  localparam logic [31:0] ExcAddrErr   = 32'h0000_000f;

  // Bit positions inside mem_exc_flags_i
  localparam int FlagSyscall = 8;
  localparam int FlagInvInst = 9;
  localparam int FlagTrap    = 10;
  localparam int FlagOvf     = 11;
  localparam int FlagEret    = 12;
  localparam int FlagAddrErr = 13;

  // CP0 register numbers targeted by mtc0
  localparam logic [4:0] CP0_REG_STATUS = 5'd12;
  localparam logic [4:0] CP0_REG_CAUSE  = 5'd13;
  localparam logic [4:0] CP0_REG_EPC    = 5'd14;
  localparam logic [4:0] CP0_REG_EBASE  = 5'd15;

  // Only IP[1:0] (software interrupts) and IV/WP are writable in cause
  localparam logic [31:0] CauseWrMask = 32'h00c0_0300;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FLUSH = 2'd1,
    ST_DRAIN = 2'd2
  } exc_state_e;

endpackage

// File: rtl/exc_ctrl_cp0_fwd.sv
// rtl/exc_ctrl_cp0_fwd.sv - combinational WB-stage mtc0 forwarding onto CP0 register values
//
// Purpose: present the CP0 status/cause/epc/ebase values as they will be once
//          the mtc0 currently in WB has been committed.
// Ports:
//   i_status/i_cause/i_epc/i_ebase  CP0 register values (32 each)
//   i_wb_we, i_wb_waddr, i_wb_data  WB-stage mtc0 write
//   o_status/o_cause/o_epc/o_ebase  forwarded values (32 each)

import exc_ctrl_pkg::*;

module cp0_fwd (
  input  logic [31:0] i_status,
  input  logic [31:0] i_cause,
  input  logic [31:0] i_epc,
  input  logic [31:0] i_ebase,
  input  logic        i_wb_we,
  input  logic [4:0]  i_wb_waddr,
  input  logic [31:0] i_wb_data,
  output logic [31:0] o_status,
  output logic [31:0] o_cause,
  output logic [31:0] o_epc,
  output logic [31:0] o_ebase
);

  always_comb begin
    o_status = i_status;
    o_cause  = i_cause;
    o_epc    = i_epc;
    o_ebase  = i_ebase;
    if (i_wb_we) begin
      case (i_wb_waddr)
        CP0_REG_STATUS: o_status = i_wb_data;
        // hardware-owned cause bits (IP7..IP2, ExcCode, BD) keep the CP0 value
        CP0_REG_CAUSE:  o_cause  = (i_cause & ~CauseWrMask) | (i_wb_data & CauseWrMask);
        CP0_REG_EPC:    o_epc    = i_wb_data;
        CP0_REG_EBASE:  o_ebase  = i_wb_data;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/exc_ctrl.sv
// rtl/exc_ctrl.sv - MEM-stage exception arbiter driving CP0 and the pipeline flush
//
// Purpose: prioritise MEM-stage exceptions and interrupts, report the winner to
//          CP0, and issue a registered one-cycle flush with the redirect PC,
//          then hold off further exceptions while the pipeline drains.
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   mem_exc_flags_i                raw MEM exception flags
//   current_inst_addr_i            MEM PC (0 marks a bubble)
//   is_in_delay_slot_i, mem_addr_i delay-slot flag, faulting address
//   cp0_status/cause/epc/ebase_i   CP0 register values
//   wb_cp0_we/waddr/data_i         WB-stage mtc0 write
//   excepttype_o, bad_address_o,
//   current_inst_addr_o,
//   is_in_delay_slot_o             to CP0 (combinational)
//   flush_o, new_pc_o              registered flush pulse and target
//   busy_o                         high while flushing or draining

import exc_ctrl_pkg::*;

module exc_ctrl #(
  parameter logic [11:0] EXC_OFFSET   = 12'h180,
  parameter int          DRAIN_CYCLES = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] mem_exc_flags_i,
  input  logic [31:0] current_inst_addr_i,
  input  logic        is_in_delay_slot_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] cp0_status_i,
  input  logic [31:0] cp0_cause_i,
  input  logic [31:0] cp0_epc_i,
  input  logic [31:0] cp0_ebase_i,
  input  logic        wb_cp0_we_i,
  input  logic [4:0]  wb_cp0_waddr_i,
  input  logic [31:0] wb_cp0_data_i,
  output logic [31:0] excepttype_o,
  output logic [31:0] bad_address_o,
  output logic [31:0] current_inst_addr_o,
  output logic        is_in_delay_slot_o,
  output logic        flush_o,
  output logic [31:0] new_pc_o,
  output logic        busy_o
);

  localparam int CntW = 8;

  exc_state_e        r_state, w_state_nxt;
  logic [CntW-1:0]   r_cnt, w_cnt_nxt;
  logic              r_flush, w_flush_nxt;
  logic [31:0]       r_new_pc, w_new_pc_nxt;

  logic [31:0] w_status, w_cause, w_epc, w_ebase;
  logic        w_int_pending;
  logic [31:0] w_exc_raw;
  logic        w_exc_allowed;

  cp0_fwd u_cp0_fwd (
    .i_status   (cp0_status_i),
    .i_cause    (cp0_cause_i),
    .i_epc      (cp0_epc_i),
    .i_ebase    (cp0_ebase_i),
    .i_wb_we    (wb_cp0_we_i),
    .i_wb_waddr (wb_cp0_waddr_i),
    .i_wb_data  (wb_cp0_data_i),
    .o_status   (w_status),
    .o_cause    (w_cause),
    .o_epc      (w_epc),
    .o_ebase    (w_ebase)
  );

  // IE set, EXL clear, some unmasked IP, and a real instruction to attach it to
  assign w_int_pending = (|(w_cause[15:8] & w_status[15:8])) && w_status[0] &&
                         !w_status[1] && (current_inst_addr_i != 32'h0);

  always_comb begin
    w_exc_raw = ExcNone;
    if (w_int_pending)                         w_exc_raw = ExcInterrupt;
    else if (mem_exc_flags_i[FlagAddrErr])     w_exc_raw = ExcAddrErr;
    else if (mem_exc_flags_i[FlagInvInst])     w_exc_raw = ExcInvInst;
    else if (mem_exc_flags_i[FlagSyscall])     w_exc_raw = ExcSyscall;
    else if (mem_exc_flags_i[FlagTrap])        w_exc_raw = ExcTrap;
    else if (mem_exc_flags_i[FlagOvf])         w_exc_raw = ExcOverflow;
    else if (mem_exc_flags_i[FlagEret])        w_exc_raw = ExcEret;
  end

  assign w_exc_allowed = (r_state == ST_IDLE) && !rst && (current_inst_addr_i != 32'h0);

  assign excepttype_o        = w_exc_allowed ? w_exc_raw : ExcNone;
  assign bad_address_o       = (excepttype_o == ExcAddrErr) ? mem_addr_i : 32'h0;
  assign current_inst_addr_o = current_inst_addr_i;
  assign is_in_delay_slot_o  = is_in_delay_slot_i;
  assign flush_o             = r_flush;
  assign new_pc_o            = r_new_pc;
  assign busy_o              = (r_state != ST_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_flush  <= 1'b0;
      r_new_pc <= 32'h0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_flush  <= w_flush_nxt;
      r_new_pc <= w_new_pc_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_flush_nxt  = 1'b0;
    w_new_pc_nxt = r_new_pc;
    case (r_state)
      ST_IDLE: begin
        if (excepttype_o != ExcNone) begin
          w_state_nxt  = ST_FLUSH;
          w_flush_nxt  = 1'b1;
          w_new_pc_nxt = (excepttype_o == ExcEret) ? w_epc :
                         ({w_ebase[31:12], 12'h000} + {20'h0, EXC_OFFSET});
        end
      end
      ST_FLUSH: begin
        if (DRAIN_CYCLES == 0) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_DRAIN;
          w_cnt_nxt   = CntW'(DRAIN_CYCLES - 1);
        end
      end
      ST_DRAIN: begin
        if (r_cnt == '0) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  logic w_unused;
  assign w_unused = &{1'b0, mem_exc_flags_i[31:14], mem_exc_flags_i[7:0],
                      w_status[31:16], w_status[7:2], w_cause[31:16],
                      w_cause[7:0], w_ebase[11:0]};

endmodule
